// File: rtl/bus_pkg.sv
// Shared constants for the datapath bus: source indices and arbitration modes.
package bus_pkg;
  localparam int R0_IDX  = 0,  R1_IDX  = 1,  R2_IDX  = 2,  R3_IDX  = 3;
  localparam int R4_IDX  = 4,  R5_IDX  = 5,  R6_IDX  = 6,  R7_IDX  = 7;
  localparam int R8_IDX  = 8,  R9_IDX  = 9,  R10_IDX = 10, R11_IDX = 11;
  localparam int R12_IDX = 12, R13_IDX = 13, R14_IDX = 14, R15_IDX = 15;
  localparam int HI_IDX  = 16, LO_IDX  = 17, ZHI_IDX = 18, ZLO_IDX = 19;
  localparam int PC_IDX  = 20, MDR_IDX = 21;

  localparam int NSRC_DEFAULT = 22;
  localparam int ARB_PRIORITY = 0;
  localparam int ARB_RR       = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bus_arbiter_mux_if.sv
// Source request/data bundle and registered bus outputs of bus_arbiter_mux.
interface bus_arbiter_mux_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 22,
  parameter int CNT_W = 16
);
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_req;
  logic                  lock;
  logic                  conflict_clr;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [NSRC-1:0]       grant;
  logic                  conflict;
  logic                  conflict_sticky;
  logic [CNT_W-1:0]      xfer_count;

  modport master (
    output src_data, src_req, lock, conflict_clr,
    input  bus_out, bus_valid, grant, conflict, conflict_sticky, xfer_count
  );

  modport slave (
    input  src_data, src_req, lock, conflict_clr,
    output bus_out, bus_valid, grant, conflict, conflict_sticky, xfer_count
  );
endinterface

// File: rtl/bus_arbiter_mux_rr_arbiter.sv
// Combinational winner select: highest-index priority, or round-robin after ptr
// with an optional lock that re-grants the current holder while it still requests.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int NSRC     = NSRC_DEFAULT,
  parameter int ARB_MODE = ARB_PRIORITY,
  localparam int IW      = idx_w(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            lock,
  input  logic [NSRC-1:0] cur_grant,
  output logic [NSRC-1:0] win,
  output logic [IW-1:0]   win_idx,
  output logic            found,
  output logic            held
);

  always_comb begin
    int j;
    j       = 0;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    held    = 1'b0;
    if (ARB_MODE == ARB_PRIORITY) begin
      // later iterations overwrite, so the highest set index survives
      for (int i = 0; i < NSRC; i++) begin
        if (req[i]) begin
          win_idx = IW'(i);
          found   = 1'b1;
        end
      end
    end else if (lock && |(req & cur_grant)) begin
      held  = 1'b1;
      found = 1'b1;
      for (int i = 0; i < NSRC; i++) begin
        if (cur_grant[i]) win_idx = IW'(i);
      end
    end else begin
      for (int k = 1; k <= NSRC; k++) begin
        j = (int'(ptr) + k) % NSRC;
        if (!found && req[j]) begin
          win_idx = IW'(j);
          found   = 1'b1;
        end
      end
    end
    if (found) win[win_idx] = 1'b1;
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered shared-bus mux: arbitrates NSRC sources, one cycle from request to bus_out.
// No backpressure; requests are not queued, so a losing source must re-request.
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NSRC      = NSRC_DEFAULT,
  parameter int ARB_MODE  = ARB_PRIORITY,
  parameter int HOLD_LAST = 1,
  parameter int CNT_W     = 16
) (
  input logic             clk,
  input logic             clr,
  bus_arbiter_mux_if.slave bus
);

  localparam int IW = idx_w(NSRC);

  logic [IW-1:0]    ptr;
  logic [NSRC-1:0]  win;
  logic [IW-1:0]    win_idx;
  logic             found;
  logic             held;
  logic [WIDTH-1:0] win_dat;
  logic             multi;

  rr_arbiter #(
    .NSRC     (NSRC),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .req       (bus.src_req),
    .ptr       (ptr),
    .lock      (bus.lock),
    .cur_grant (bus.grant),
    .win       (win),
    .win_idx   (win_idx),
    .found     (found),
    .held      (held)
  );

  assign win_dat = bus.src_data[int'(win_idx)*WIDTH +: WIDTH];
  // clearing the lowest set bit leaves something only if two or more were set
  assign multi   = |(bus.src_req & (bus.src_req - NSRC'(1)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus.bus_out         <= '0;
      bus.bus_valid       <= 1'b0;
      bus.grant           <= '0;
      bus.conflict        <= 1'b0;
      bus.conflict_sticky <= 1'b0;
      bus.xfer_count      <= '0;
      ptr                 <= IW'(NSRC - 1);
    end else begin
      bus.conflict <= multi;
      if (multi)                 bus.conflict_sticky <= 1'b1;
      else if (bus.conflict_clr) bus.conflict_sticky <= 1'b0;

      if (found) begin
        bus.bus_out    <= win_dat;
        bus.grant      <= win;
        bus.bus_valid  <= 1'b1;
        bus.xfer_count <= bus.xfer_count + CNT_W'(1);
        if (!held) ptr <= win_idx;
      end else begin
        bus.bus_valid <= 1'b0;
        bus.grant     <= '0;
        if (HOLD_LAST == 0) bus.bus_out <= '0;
      end
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (clr) $onehot0(bus.grant));

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Directed bench: a priority/hold-last instance and a round-robin/clear-when-idle/4-bit-counter instance.
module tb_bus_arbiter_mux;
  import bus_pkg::*;

  localparam int W = 32;
  localparam int N = 22;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bus_arbiter_mux_if #(.WIDTH(W), .NSRC(N), .CNT_W(16)) bif_p ();
  bus_arbiter_mux_if #(.WIDTH(W), .NSRC(N), .CNT_W(4))  bif_r ();

  bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .ARB_MODE(ARB_PRIORITY), .HOLD_LAST(1), .CNT_W(16))
    dut_p (.clk(clk), .clr(clr), .bus(bif_p));
  bus_arbiter_mux #(.WIDTH(W), .NSRC(N), .ARB_MODE(ARB_RR), .HOLD_LAST(0), .CNT_W(4))
    dut_r (.clk(clk), .clr(clr), .bus(bif_r));

  function automatic logic [W-1:0] word_of(input int i);
    case (i)
      PC_IDX:  return 32'h0000_0040;
      MDR_IDX: return 32'hDEAD_BEEF;
      R4_IDX:  return 32'h1234_5678;
      default: return 32'hC0DE_0000 | 32'(i);
    endcase
  endfunction

  function automatic logic [N-1:0] bit_of(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive(input logic [N-1:0] req, input logic lk, input logic cc);
    bif_p.src_req = req;  bif_r.src_req = req;
    bif_p.lock = lk;      bif_r.lock = lk;
    bif_p.conflict_clr = cc;
    bif_r.conflict_clr = cc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      bif_p.src_data[i*W +: W] = word_of(i);
      bif_r.src_data[i*W +: W] = word_of(i);
    end
    clr = 1'b1;
    drive('0, 1'b0, 1'b0);
    step(); step();
    clr = 1'b0;
    step(); step(); step();
    checks++;
    if ({bif_p.bus_out, bif_p.bus_valid, bif_p.grant, bif_p.conflict, bif_p.conflict_sticky, bif_p.xfer_count} !== '0) begin
      errors++; $display("FAIL reset_p: got bus=%h vld=%b gnt=%h cnt=%h stk=%b, need all zero",
                         bif_p.bus_out, bif_p.bus_valid, bif_p.grant, bif_p.xfer_count, bif_p.conflict_sticky);
    end
    checks++;
    if ({bif_r.bus_out, bif_r.bus_valid, bif_r.grant, bif_r.conflict, bif_r.conflict_sticky, bif_r.xfer_count} !== '0) begin
      errors++; $display("FAIL reset_r: got bus=%h vld=%b gnt=%h cnt=%h stk=%b, need all zero",
                         bif_r.bus_out, bif_r.bus_valid, bif_r.grant, bif_r.xfer_count, bif_r.conflict_sticky);
    end
  endtask

  task automatic test_round_robin();
    int exp_src[4];
    exp_src = '{0, 5, 21, 0};
    drive(bit_of(0) | bit_of(5) | bit_of(21), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bif_r.grant !== bit_of(exp_src[k])) begin
        errors++; $display("FAIL rr_grant%0d: got %h need %h", k, bif_r.grant, bit_of(exp_src[k]));
      end
      checks++;
      if (bif_r.bus_out !== word_of(exp_src[k])) begin
        errors++; $display("FAIL rr_bus%0d: got %h need %h", k, bif_r.bus_out, word_of(exp_src[k]));
      end
    end
    checks++;
    if (bif_r.conflict !== 1'b1) begin
      errors++; $display("FAIL rr_conflict: got %b need 1", bif_r.conflict);
    end
    checks++;
    if (bif_p.grant !== bit_of(MDR_IDX)) begin
      errors++; $display("FAIL pri_rr_grant: got %h need %h", bif_p.grant, bit_of(MDR_IDX));
    end
  endtask

  task automatic test_lock();
    int exp_src[4];
    exp_src = '{3, 3, 3, 7};
    for (int k = 0; k < 4; k++) begin
      drive((k == 3) ? bit_of(7) : (bit_of(3) | bit_of(7)), (k != 0), 1'b0);
      step();
      checks++;
      if (bif_r.grant !== bit_of(exp_src[k])) begin
        errors++; $display("FAIL lock_grant%0d: got %h need %h", k, bif_r.grant, bit_of(exp_src[k]));
      end
      if (k == 1) begin
        checks++;
        if (bif_p.grant !== bit_of(7)) begin
          errors++; $display("FAIL lock_ignored_pri: got %h need %h", bif_p.grant, bit_of(7));
        end
      end
    end
  endtask

  task automatic test_priority();
    drive(bit_of(PC_IDX) | bit_of(MDR_IDX), 1'b0, 1'b0);
    step();
    checks++;
    if (bif_p.bus_out !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL pri_bus: got %h need deadbeef", bif_p.bus_out);
    end
    checks++;
    if (bif_p.grant !== bit_of(MDR_IDX)) begin
      errors++; $display("FAIL pri_grant: got %h need %h", bif_p.grant, bit_of(MDR_IDX));
    end
    checks++;
    if ({bif_p.conflict, bif_p.conflict_sticky} !== 2'b11) begin
      errors++; $display("FAIL pri_conflict: got %b%b need 11", bif_p.conflict, bif_p.conflict_sticky);
    end
    checks++;
    if (bif_p.xfer_count !== 16'd9) begin
      errors++; $display("FAIL pri_count: got %0d need 9", bif_p.xfer_count);
    end
    checks++;
    if ({bif_r.grant, bif_r.bus_out} !== {bit_of(PC_IDX), 32'h0000_0040}) begin
      errors++; $display("FAIL rr_after_lock: got gnt=%h bus=%h need gnt=%h bus=00000040",
                         bif_r.grant, bif_r.bus_out, bit_of(PC_IDX));
    end

    drive('0, 1'b0, 1'b1);
    step();
    checks++;
    if ({bif_p.conflict, bif_p.conflict_sticky} !== 2'b00) begin
      errors++; $display("FAIL sticky_clear: got %b%b need 00", bif_p.conflict, bif_p.conflict_sticky);
    end
    checks++;
    if ({bif_p.bus_out, bif_p.bus_valid, bif_p.grant, bif_p.xfer_count} !== {32'hDEAD_BEEF, 1'b0, {N{1'b0}}, 16'd9}) begin
      errors++; $display("FAIL pri_idle: got bus=%h vld=%b gnt=%h cnt=%0d need deadbeef/0/0/9",
                         bif_p.bus_out, bif_p.bus_valid, bif_p.grant, bif_p.xfer_count);
    end
    checks++;
    if ({bif_r.bus_out, bif_r.bus_valid, bif_r.conflict_sticky} !== {32'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rr_idle: got bus=%h vld=%b stk=%b need 0/0/0",
                         bif_r.bus_out, bif_r.bus_valid, bif_r.conflict_sticky);
    end

    drive(bit_of(R0_IDX) | bit_of(HI_IDX), 1'b0, 1'b1);
    step();
    checks++;
    if ({bif_p.grant, bif_p.bus_out} !== {bit_of(HI_IDX), 32'hC0DE_0010}) begin
      errors++; $display("FAIL pri_hi: got gnt=%h bus=%h need gnt=%h bus=c0de0010",
                         bif_p.grant, bif_p.bus_out, bit_of(HI_IDX));
    end
    checks++;
    if (bif_p.conflict_sticky !== 1'b1) begin
      errors++; $display("FAIL sticky_set_wins: got %b need 1", bif_p.conflict_sticky);
    end
    checks++;
    if (bif_r.grant !== bit_of(R0_IDX)) begin
      errors++; $display("FAIL rr_wrap_ptr: got %h need %h", bif_r.grant, bit_of(R0_IDX));
    end

    drive('0, 1'b0, 1'b1);
    step();
    checks++;
    if (bif_p.conflict_sticky !== 1'b0) begin
      errors++; $display("FAIL sticky_clear2: got %b need 0", bif_p.conflict_sticky);
    end
    drive('0, 1'b0, 1'b0);
  endtask

  task automatic test_idle_hold();
    drive(bit_of(R4_IDX), 1'b0, 1'b0);
    step();
    checks++;
    if ({bif_p.bus_out, bif_r.bus_out} !== {32'h1234_5678, 32'h1234_5678}) begin
      errors++; $display("FAIL r4_load: got p=%h r=%h need 12345678", bif_p.bus_out, bif_r.bus_out);
    end
    checks++;
    if (bif_p.conflict !== 1'b0) begin
      errors++; $display("FAIL single_no_conflict: got %b need 0", bif_p.conflict);
    end
    drive('0, 1'b0, 1'b0);
    step();
    checks++;
    if ({bif_p.bus_out, bif_p.bus_valid, bif_p.grant} !== {32'h1234_5678, 1'b0, {N{1'b0}}}) begin
      errors++; $display("FAIL hold_last: got bus=%h vld=%b gnt=%h need 12345678/0/0",
                         bif_p.bus_out, bif_p.bus_valid, bif_p.grant);
    end
    checks++;
    if ({bif_r.bus_out, bif_r.bus_valid, bif_r.grant} !== {32'h0, 1'b0, {N{1'b0}}}) begin
      errors++; $display("FAIL clear_idle: got bus=%h vld=%b gnt=%h need 0/0/0",
                         bif_r.bus_out, bif_r.bus_valid, bif_r.grant);
    end
    step();
    checks++;
    if ({bif_p.bus_out, bif_p.xfer_count, bif_r.xfer_count} !== {32'h1234_5678, 16'd11, 4'd11}) begin
      errors++; $display("FAIL idle_counts: got bus=%h p=%0d r=%0d need 12345678/11/11",
                         bif_p.bus_out, bif_p.xfer_count, bif_r.xfer_count);
    end
  endtask

  task automatic test_counter_wrap();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if ({bif_p.xfer_count, bif_r.xfer_count} !== {16'd0, 4'd0}) begin
      errors++; $display("FAIL wrap_start: got p=%0d r=%0d need 0/0", bif_p.xfer_count, bif_r.xfer_count);
    end
    for (int k = 0; k < 16; k++) begin
      drive(bit_of(k), 1'b0, 1'b0);
      step();
      checks++;
      if (bif_r.xfer_count !== 4'(k + 1)) begin
        errors++; $display("FAIL wrap_count%0d: got %0d need %0d", k, bif_r.xfer_count, 4'(k + 1));
      end
    end
    checks++;
    if ({bif_p.xfer_count, bif_r.bus_out} !== {16'd16, 32'hC0DE_000F}) begin
      errors++; $display("FAIL wrap_end: got p=%0d bus=%h need 16/c0de000f", bif_p.xfer_count, bif_r.bus_out);
    end
  endtask

  task automatic test_mid_reset();
    drive(bit_of(R2_IDX), 1'b0, 1'b0);
    step();
    #3;
    clr = 1'b1;
    #1;
    checks++;
    if ({bif_p.bus_out, bif_p.bus_valid, bif_p.grant, bif_p.xfer_count} !== '0) begin
      errors++; $display("FAIL async_clr_p: got bus=%h vld=%b gnt=%h cnt=%0d need all zero",
                         bif_p.bus_out, bif_p.bus_valid, bif_p.grant, bif_p.xfer_count);
    end
    checks++;
    if ({bif_r.bus_out, bif_r.bus_valid, bif_r.grant, bif_r.xfer_count} !== '0) begin
      errors++; $display("FAIL async_clr_r: got bus=%h vld=%b gnt=%h cnt=%0d need all zero",
                         bif_r.bus_out, bif_r.bus_valid, bif_r.grant, bif_r.xfer_count);
    end
    step();
    clr = 1'b0;
    drive(bit_of(R0_IDX) | bit_of(MDR_IDX), 1'b0, 1'b0);
    step();
    checks++;
    if ({bif_r.grant, bif_r.bus_out, bif_r.xfer_count} !== {bit_of(R0_IDX), 32'hC0DE_0000, 4'd1}) begin
      errors++; $display("FAIL post_clr_rr: got gnt=%h bus=%h cnt=%0d need %h/c0de0000/1",
                         bif_r.grant, bif_r.bus_out, bif_r.xfer_count, bit_of(R0_IDX));
    end
    checks++;
    if ({bif_p.grant, bif_p.conflict} !== {bit_of(MDR_IDX), 1'b1}) begin
      errors++; $display("FAIL post_clr_pri: got gnt=%h cf=%b need %h/1", bif_p.grant, bif_p.conflict, bit_of(MDR_IDX));
    end
    drive('0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_priority();
    test_idle_hold();
    test_counter_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
